// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared TMDS control tokens, alignment states and symbol decode
// Contents:
//   CTRL_TOKEN_* : the four 10-bit TMDS control symbols, written as q[9:0]
//   CTRL_*       : the matching {C1,C0} codes
//   align_state_e: symbol aligner states
//   tmds_sym_t   : decoded symbol {de, c, d}
//   tmds_decode  : 10-bit symbol -> tmds_sym_t
package dvi_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [1:0] CTRL_00 = 2'b00;
  localparam logic [1:0] CTRL_01 = 2'b01;
  localparam logic [1:0] CTRL_10 = 2'b10;
  localparam logic [1:0] CTRL_11 = 2'b11;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
  } tmds_sym_t;

  // Control symbols return de=0 with their code and d=0; every other
  // symbol is treated as video data and returns de=1 with c=0.
  function automatic tmds_sym_t tmds_decode(input logic [9:0] q);
    tmds_sym_t  r;
    logic [7:0] p;
    r.de = 1'b1;
    r.c  = CTRL_00;
    r.d  = 8'h00;
    p    = 8'h00;
    case (q)
      CTRL_TOKEN_00: begin r.de = 1'b0; r.c = CTRL_00; end
      CTRL_TOKEN_01: begin r.de = 1'b0; r.c = CTRL_01; end
      CTRL_TOKEN_10: begin r.de = 1'b0; r.c = CTRL_10; end
      CTRL_TOKEN_11: begin r.de = 1'b0; r.c = CTRL_11; end
      default: begin
        // q[9] flags a DC-balance inversion, q[8] selects XOR vs XNOR chaining.
        p = q[9] ? ~q[7:0] : q[7:0];
        r.d[0] = p[0];
        for (int i = 1; i < 8; i++) begin
          r.d[i] = q[8] ? (p[i] ^ p[i-1]) : ~(p[i] ^ p[i-1]);
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - finds the 10-bit symbol boundary from control-token runs
// Ports:
//   clk_i, rst_i : pixel clock, asynchronous active-high reset
//   raw_i[9:0]   : unaligned deserialised word, raw_i[0] earliest
//   sym_o[9:0]   : aligned symbol, registered (sym_q)
//   locked_o     : FSM is in LOCKED
//   offset_o[3:0]: current bit offset 0..9
module tmds_word_aligner
  import dvi_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WIN   = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_i,
  output logic [9:0] sym_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  localparam int WIN_W = $clog2(SEARCH_WIN);
  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int TMR_W = $clog2(LOSS_TIMEOUT);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WIN - 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(CTRL_RUN);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOSS_TIMEOUT - 1);

  align_state_e     state_q,  state_d;
  logic [9:0]       prev_q,   prev_d;
  logic [9:0]       sym_q,    sym_d;
  logic [3:0]       offset_q, offset_d;
  logic [WIN_W-1:0] win_q,    win_d;
  logic [RUN_W-1:0] run_q,    run_d;
  logic [TMR_W-1:0] tmr_q,    tmr_d;

  logic [19:0]      stream;
  logic [9:0]       w;
  logic             is_ctrl;
  logic [RUN_W-1:0] run_inc;
  tmds_sym_t        w_dec;

  // Window select: older word in the low half so w[0] is the earliest bit.
  always_comb begin
    stream = {raw_i, prev_q};
    w      = stream[9:0];
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) begin
        w = stream[i +: 10];
      end
    end
    w_dec   = tmds_decode(w);
    is_ctrl = ~w_dec.de;
    // Saturating, so a long token stream keeps qualifying every cycle.
    run_inc = (run_q == RUN_FULL) ? run_q : run_q + RUN_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = raw_i;
    sym_d    = w;
    offset_d = offset_q;
    win_d    = win_q;
    run_d    = run_q;
    tmr_d    = tmr_q;
    case (state_q)
      SEARCH: begin
        if (is_ctrl) begin
          state_d = VERIFY;
          run_d   = RUN_W'(1);
        end else if (win_q == WIN_LAST) begin
          win_d    = '0;
          offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      VERIFY: begin
        if (is_ctrl) begin
          run_d = run_inc;
          if (run_inc == RUN_FULL) begin
            state_d = LOCKED;
            tmr_d   = '0;
          end
        end else begin
          state_d = SEARCH;
          win_d   = '0;
          run_d   = '0;
        end
      end
      LOCKED: begin
        run_d = is_ctrl ? run_inc : '0;
        // A completed run takes priority over an expiring timer.
        if (is_ctrl && (run_inc == RUN_FULL)) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = SEARCH;
          win_d   = '0;
          run_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = SEARCH;
        win_d   = '0;
        run_d   = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SEARCH;
      prev_q   <= '0;
      sym_q    <= '0;
      offset_q <= '0;
      win_q    <= '0;
      run_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      sym_q    <= sym_d;
      offset_q <= offset_d;
      win_q    <= win_d;
      run_q    <= run_d;
      tmr_q    <= tmr_d;
    end
  end

  assign sym_o    = sym_q;
  assign locked_o = (state_q == LOCKED);
  assign offset_o = offset_q;

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - one TMDS lane: word alignment plus symbol decode
// Ports:
//   clk_i, rst_i : pixel clock, asynchronous active-high reset
//   raw_i[9:0]   : deserialised word, raw_i[0] earliest
//   data_o[7:0]  : decoded pixel byte
//   de_o         : 1 = data_o valid, 0 = control period
//   c_o[1:0]     : control bits {C1,C0}, held through data periods
//   locked_o     : symbol alignment established
//   offset_o[3:0]: current bit offset 0..9
module tmds_channel_decoder
  import dvi_pkg::*;
#(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WIN   = 2048,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_i,
  output logic [7:0] data_o,
  output logic       de_o,
  output logic [1:0] c_o,
  output logic       locked_o,
  output logic [3:0] offset_o
);

  logic [9:0] sym;
  logic       aligned;
  tmds_sym_t  dec;

  logic [7:0] data_q,   data_d;
  logic       de_q,     de_d;
  logic [1:0] c_q,      c_d;
  logic       locked_q, locked_d;

  tmds_word_aligner #(
    .CTRL_RUN    (CTRL_RUN),
    .SEARCH_WIN  (SEARCH_WIN),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) u_aligner (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .raw_i   (raw_i),
    .sym_o   (sym),
    .locked_o(aligned),
    .offset_o(offset_o)
  );

  // locked_o passes through this stage too so it lines up with the
  // decoded symbol that was aligned under the same lock state.
  always_comb begin
    dec      = tmds_decode(sym);
    data_d   = 8'h00;
    de_d     = 1'b0;
    c_d      = 2'b00;
    locked_d = aligned;
    if (aligned) begin
      de_d   = dec.de;
      data_d = dec.d;
      c_d    = dec.de ? c_q : dec.c;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q   <= '0;
      de_q     <= 1'b0;
      c_q      <= '0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      de_q     <= de_d;
      c_q      <= c_d;
      locked_q <= locked_d;
    end
  end

  assign data_o   = data_q;
  assign de_o     = de_q;
  assign c_o      = c_q;
  assign locked_o = locked_q;

endmodule
